// File: rtl/rename_pkg.sv
// Shared constants and types for the rename/allocate front end.
// Tags are 6-bit physical register names; arch regs are 5-bit.
package rename_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int PTAG_W   = 6;
  localparam int AREG_W   = 5;

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [AREG_W-1:0] areg_t;

  // Tags 0..31 back the identity mapping; 32..63 start free.
  localparam logic [NUM_PHYS-1:0] FREE_RST =
    {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

endpackage

// File: rtl/rename_alloc_unit_if.sv
// Handshake, ROB alloc/commit/free and recovery signals of the rename unit.
// The master side drives instructions in; the slave side is the rename unit.
interface rename_alloc_unit_if;
  import rename_pkg::*;

  logic  in_valid;
  logic  in_ready;
  areg_t in_rs1;
  areg_t in_rs2;
  areg_t in_rd;
  logic  in_rd_wen;

  logic  out_valid;
  logic  out_ready;
  ptag_t out_ps1;
  ptag_t out_ps2;
  ptag_t out_pd;
  ptag_t out_old_pd;

  logic  alloc_valid;
  areg_t alloc_dest_arch;
  ptag_t alloc_dest_phys;
  logic  alloc_accepted;

  logic  commit_valid;
  areg_t commit_dest_arch;
  ptag_t commit_dest_phys;

  logic  free_phys_valid;
  ptag_t free_phys;

  logic  recover;
  logic  busy_recover;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
    input  in_ready,
    input  out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
    output out_ready,
    input  alloc_valid, alloc_dest_arch, alloc_dest_phys,
    output alloc_accepted,
    output commit_valid, commit_dest_arch, commit_dest_phys,
    output free_phys_valid, free_phys,
    output recover,
    input  busy_recover
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
    output in_ready,
    output out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
    input  out_ready,
    output alloc_valid, alloc_dest_arch, alloc_dest_phys,
    input  alloc_accepted,
    input  commit_valid, commit_dest_arch, commit_dest_phys,
    input  free_phys_valid, free_phys,
    input  recover,
    output busy_recover
  );

endinterface

// File: rtl/free_list_bitvec.sv
// Bit-vector free list: lowest-set-bit allocate, tag return, bulk rebuild.
// A returned tag only becomes visible to allocation on the next cycle.
module free_list_bitvec
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_en,
  output ptag_t               alloc_tag,
  output logic                any_free,
  input  logic                ret_en,
  input  ptag_t               ret_tag,
  input  logic                rebuild_en,
  input  logic [NUM_PHYS-1:0] rebuild_mask
);

  logic [NUM_PHYS-1:0] vec;

  // Priority pick of the lowest free tag.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_PHYS-1; i >= 0; i--) begin
      if (vec[i]) alloc_tag = ptag_t'(i);
    end
  end

  assign any_free = |vec;

  // Rebuild wins over allocate/return; tag 0 is never freed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec <= FREE_RST;
    end else if (rebuild_en) begin
      vec <= {rebuild_mask[NUM_PHYS-1:1], 1'b0};
    end else begin
      if (alloc_en) vec[alloc_tag] <= 1'b0;
      if (ret_en && ret_tag != '0) vec[ret_tag] <= 1'b1;
    end
  end

endmodule

// File: rtl/rename_alloc_unit.sv
// Rename stage: speculative/committed RAT, free list, ROB alloc, recovery.
// Optional stall counter enabled by defining RENAME_PERF_CNT_EN.
module rename_alloc_unit
  import rename_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  rename_alloc_unit_if.slave    bus
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]           stall_free_cnt
`endif
);

  state_t state;
  ptag_t  spec_rat [NUM_ARCH];
  ptag_t  cmt_rat  [NUM_ARCH];
  ptag_t  cmt_next [NUM_ARCH];

  logic                out_valid_q;
  ptag_t               ps1_q;
  ptag_t               ps2_q;
  ptag_t               pd_q;
  ptag_t               old_q;
  areg_t               arch_q;

  ptag_t               alloc_tag;
  logic                any_free;
  logic                need_dest;
  logic                drain;
  logic                fire;
  ptag_t               src1;
  ptag_t               src2;
  logic [NUM_PHYS-1:0] used;
  logic [NUM_PHYS-1:0] rebuild_mask;

  assign need_dest = bus.in_rd_wen && (bus.in_rd != '0);
  assign drain     = bus.out_ready && bus.alloc_accepted;

  assign bus.in_ready = (state == RUN) && !bus.recover
                      && (!out_valid_q || drain)
                      && (!need_dest || any_free);

  assign fire = bus.in_valid && bus.in_ready;

  assign src1 = (bus.in_rs1 == '0) ? '0 : spec_rat[bus.in_rs1];
  assign src2 = (bus.in_rs2 == '0) ? '0 : spec_rat[bus.in_rs2];

  // Committed map as it will stand after this cycle's commit.
  always_comb begin
    cmt_next = cmt_rat;
    if (bus.commit_valid && bus.commit_dest_arch != '0)
      cmt_next[bus.commit_dest_arch] = bus.commit_dest_phys;
  end

  // Free tags after recovery: everything the committed map does not hold.
  always_comb begin
    used = '0;
    for (int a = 0; a < NUM_ARCH; a++) used[cmt_next[a]] = 1'b1;
    rebuild_mask    = ~used;
    rebuild_mask[0] = 1'b0;
  end

  free_list_bitvec u_free (
    .clk          (clk),
    .reset        (reset),
    .alloc_en     (fire && need_dest),
    .alloc_tag    (alloc_tag),
    .any_free     (any_free),
    .ret_en       (bus.free_phys_valid),
    .ret_tag      (bus.free_phys),
    .rebuild_en   (state == RECOVER),
    .rebuild_mask (rebuild_mask)
  );

  // Speculative RAT: restored wholesale in RECOVER, else updated on fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) spec_rat[i] <= ptag_t'(i);
    end else if (state == RECOVER) begin
      spec_rat <= cmt_next;
    end else if (fire && need_dest) begin
      spec_rat[bus.in_rd] <= alloc_tag;
    end
  end

  // Committed RAT follows the ROB commit stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) cmt_rat[i] <= ptag_t'(i);
    end else begin
      cmt_rat <= cmt_next;
    end
  end

  // Control FSM and registered output bundle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      out_valid_q <= 1'b0;
      ps1_q       <= '0;
      ps2_q       <= '0;
      pd_q        <= '0;
      old_q       <= '0;
      arch_q      <= '0;
    end else begin
      state <= bus.recover ? RECOVER : RUN;
      if (bus.recover) begin
        out_valid_q <= 1'b0;
      end else if (fire) begin
        out_valid_q <= 1'b1;
        ps1_q       <= src1;
        ps2_q       <= src2;
        pd_q        <= need_dest ? alloc_tag : '0;
        old_q       <= need_dest ? spec_rat[bus.in_rd] : '0;
        arch_q      <= need_dest ? bus.in_rd : '0;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_ps1         = ps1_q;
  assign bus.out_ps2         = ps2_q;
  assign bus.out_pd          = pd_q;
  assign bus.out_old_pd      = old_q;
  assign bus.alloc_valid     = out_valid_q;
  assign bus.alloc_dest_arch = arch_q;
  assign bus.alloc_dest_phys = pd_q;
  assign bus.busy_recover    = (state == RECOVER);

`ifdef RENAME_PERF_CNT_EN
  // Saturating count of cycles stalled on an empty free list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_free_cnt <= '0;
    end else if (bus.recover) begin
      stall_free_cnt <= '0;
    end else if (bus.in_valid && need_dest && !any_free
                 && stall_free_cnt != '1) begin
      stall_free_cnt <= stall_free_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_alloc_unit.sv
// Bench for rename_alloc_unit: directed scenarios plus random traffic,
// all checked against an array-based rename model.
module tb_rename_alloc_unit;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic reset;

  rename_alloc_unit_if bus();

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] stall_free_cnt;
`endif

  rename_alloc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RENAME_PERF_CNT_EN
    ,
    .stall_free_cnt (stall_free_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference model state.
  int m_spec [32];
  int m_cmt  [32];
  bit m_free [64];
  bit m_ov, m_rec;
  int m_ps1, m_ps2, m_pd, m_old, m_arch;
  bit seen_ready;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = i;
      m_cmt[i]  = i;
    end
    for (int j = 0; j < 64; j++) m_free[j] = (j >= 32);
    m_ov = 0; m_rec = 0;
    m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_old = 0; m_arch = 0;
  endfunction

  function automatic int m_lowest();
    for (int j = 0; j < 64; j++) if (m_free[j]) return j;
    return -1;
  endfunction

  task automatic drive_idle();
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_rd = 0; bus.in_rd_wen = 0;
    bus.out_ready = 1; bus.alloc_accepted = 1;
    bus.commit_valid = 0; bus.commit_dest_arch = 0;
    bus.commit_dest_phys = 0;
    bus.free_phys_valid = 0; bus.free_phys = 0;
    bus.recover = 0;
  endtask

  // One cycle: drive at negedge, check in_ready, advance, check outputs.
  task automatic step(bit v, int rs1, int rs2, int rd, bit wen,
                      bit ordy = 1, bit acc = 1,
                      bit cv = 0, int ca = 0, int cp = 0,
                      bit fv = 0, int ft = 0, bit rec = 0);
    bit need, ready, fire;
    int nc [32];
    int t;
    bus.in_valid = v;
    bus.in_rs1 = rs1[4:0]; bus.in_rs2 = rs2[4:0];
    bus.in_rd = rd[4:0]; bus.in_rd_wen = wen;
    bus.out_ready = ordy; bus.alloc_accepted = acc;
    bus.commit_valid = cv; bus.commit_dest_arch = ca[4:0];
    bus.commit_dest_phys = cp[5:0];
    bus.free_phys_valid = fv; bus.free_phys = ft[5:0];
    bus.recover = rec;
    #1;
    need  = wen && (rd != 0);
    ready = !m_rec && !rec && (!m_ov || (ordy && acc))
            && (!need || m_lowest() >= 0);
    seen_ready = bus.in_ready;
    chk("in_ready", bus.in_ready, ready);
    fire = v && ready;
    nc = m_cmt;
    if (cv && ca != 0) nc[ca] = cp;
    if (m_rec) begin
      m_spec = nc;
      for (int j = 0; j < 64; j++) m_free[j] = 1;
      for (int a = 0; a < 32; a++) m_free[nc[a]] = 0;
      m_free[0] = 0;
    end else begin
      if (fire) begin
        m_ps1 = (rs1 == 0) ? 0 : m_spec[rs1];
        m_ps2 = (rs2 == 0) ? 0 : m_spec[rs2];
        if (need) begin
          t = m_lowest();
          m_old = m_spec[rd];
          m_pd = t; m_arch = rd;
          m_free[t] = 0;
          m_spec[rd] = t;
        end else begin
          m_pd = 0; m_old = 0; m_arch = 0;
        end
      end
      if (fv && ft != 0) m_free[ft] = 1;
    end
    if (rec) m_ov = 0;
    else if (fire) m_ov = 1;
    else if (ordy && acc) m_ov = 0;
    m_rec = rec;
    m_cmt = nc;
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, m_ov);
    chk("alloc_valid", bus.alloc_valid, m_ov);
    chk("busy_recover", bus.busy_recover, m_rec);
    chk("out_ps1", bus.out_ps1, m_ps1);
    chk("out_ps2", bus.out_ps2, m_ps2);
    chk("out_pd", bus.out_pd, m_pd);
    chk("out_old_pd", bus.out_old_pd, m_old);
    chk("alloc_dest_arch", bus.alloc_dest_arch, m_arch);
    chk("alloc_dest_phys", bus.alloc_dest_phys, m_pd);
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    reset = 0;
    m_reset();
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pd", bus.out_pd, 0);
    chk("rst_busy", bus.busy_recover, 0);
    @(negedge clk);
    reset = 1;

    // First rename and back-to-back visibility.
    step(1, 5, 0, 5, 1);
    chk("d1_ps1", bus.out_ps1, 5);
    chk("d1_ps2", bus.out_ps2, 0);
    chk("d1_pd", bus.out_pd, 32);
    chk("d1_old", bus.out_old_pd, 5);
    chk("d1_arch", bus.alloc_dest_arch, 5);
    step(1, 5, 0, 0, 0);
    chk("d2_ps1", bus.out_ps1, 32);

    // Exhaust the free list.
    for (int i = 0; i < 31; i++) begin
      step(1, i % 32, 0, (i % 31) + 1, 1);
      chk("fill_pd", bus.out_pd, 33 + i);
    end
    step(1, 1, 2, 6, 1);
    chk("full_ready", seen_ready, 0);
    step(1, 1, 2, 0, 0);
    chk("nodest_ready", seen_ready, 1);
    // Return 40 while a dest instr waits: not yet allocatable.
    step(1, 1, 2, 6, 1, 1, 1, 0, 0, 0, 1, 40);
    chk("ret_same_cycle", seen_ready, 0);
    step(1, 1, 2, 6, 1);
    chk("ret_pd", bus.out_pd, 40);

    // Back-pressure from the ROB.
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 4, 0, 0, 1, 0);
      chk("hold_ready", seen_ready, 0);
      chk("hold_pd", bus.out_pd, 40);
    end
    step(1, 3, 4, 0, 0, 1, 1);
    chk("release_ready", seen_ready, 1);

    // Commit, speculative rename, then recover.
    step(0, 0, 0, 0, 0, 1, 1, 1, 3, 33);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 34);
    step(1, 3, 0, 3, 1);
    chk("spec_pd", bus.out_pd, 34);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("rec_busy", bus.busy_recover, 1);
    chk("rec_ov", bus.out_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("rec_busy_end", bus.busy_recover, 0);
    step(1, 3, 0, 7, 1);
    chk("post_ps1", bus.out_ps1, 33);
    chk("post_pd3", bus.out_pd, 3);
    step(1, 0, 0, 8, 1);
    chk("post_pd32", bus.out_pd, 32);
    step(1, 0, 0, 9, 1);
    chk("post_pd34", bus.out_pd, 34);

    // Recover racing a fire attempt.
    step(1, 1, 1, 10, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("race_ready", seen_ready, 0);
    chk("race_ov", bus.out_valid, 0);

    // Reset in the middle of RECOVER.
    drive_idle();
    #2;
    reset = 0;
    #1;
    chk("mid_rst_busy", bus.busy_recover, 0);
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_pd", bus.out_pd, 0);
    m_reset();
    @(negedge clk);
    reset = 1;
    step(1, 3, 9, 4, 1);
    chk("id_ps1", bus.out_ps1, 3);
    chk("id_ps2", bus.out_ps2, 9);
    chk("id_pd", bus.out_pd, 32);
    chk("id_old", bus.out_old_pd, 4);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(3) != 0,
           $urandom_range(31), $urandom_range(31),
           $urandom_range(31), $urandom_range(1),
           $urandom_range(7) != 0, $urandom_range(3) != 0,
           $urandom_range(2) == 0, $urandom_range(31),
           $urandom_range(63),
           $urandom_range(5) == 0, $urandom_range(63),
           $urandom_range(39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_alloc_unit.md
Name: rename_alloc_unit

Overview:
- Front-end rename stage sitting directly upstream of the reorder buffer.
- Maps architectural source/dest registers to physical tags through a speculative RAT and a bit-vector free list.
- Drives the ROB alloc interface and reclaims tags on the ROB free_phys return.
- Keeps a committed RAT and restores the speculative state from it on branch-mispredict recovery.

Parameters:
- NUM_ARCH, 32, architectural registers (x0 hardwired, never renamed).
- NUM_PHYS, 64, physical registers; tag width is clog2(NUM_PHYS) = 6.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  rename accepts this cycle.
- in_rs1, in_rs2, in_rd  in  5 each  architectural sources and destination.
- in_rd_wen  in  1  instruction writes rd.
- out_valid  out  1  renamed instruction held in the output register.
- out_ready  in  1  downstream (issue) accepts.
- out_ps1, out_ps2, out_pd  out  6 each  physical source tags and new destination tag.
- out_old_pd  out  6  previous mapping of rd.
- alloc_valid  out  1  ROB allocation request; equals out_valid.
- alloc_dest_arch  out  5  rd, or 0 when there is no destination.
- alloc_dest_phys  out  6  out_pd.
- alloc_accepted  in  1  ROB took the entry.
- commit_valid  in  1  ROB commit.
- commit_dest_arch  in  5  committed rd.
- commit_dest_phys  in  6  committed tag.
- free_phys_valid  in  1  tag returned by ROB.
- free_phys  in  6  returned tag.
- recover  in  1  mispredict flush pulse.
- busy_recover  out  1  unit is in the RECOVER state.

Behaviour:
- Reset (async, reset=0):
  - Speculative and committed RAT are identity: arch i maps to phys i.
  - Free vector has bits 32..63 set and 0..31 clear.
  - out_valid=0, all out_* = 0, busy_recover=0, state=RUN.
- States:
  - RUN goes to RECOVER when recover=1.
  - RECOVER goes to RUN after exactly one cycle.
- need_dest = in_rd_wen && in_rd != 0.
- in_ready = RUN && !recover && (!out_valid || (out_ready && alloc_accepted)) && (!need_dest || free vector nonzero).
- Fire (in_valid && in_ready), with a registered output one cycle later:
  - out_ps1/out_ps2 = spec RAT[rs]; arch 0 always maps to tag 0.
  - If need_dest: out_pd = lowest set free bit, which is then cleared; out_old_pd = RAT[rd]; RAT[rd] = out_pd.
  - If not need_dest: out_pd = 0 and out_old_pd = 0.
  - Source lookup happens before the same-cycle RAT write, so rd == rs reads the old mapping.
- Back-to-back instructions see each other's RAT update: the write lands at the fire edge.
- Output drains only when out_ready && alloc_accepted. Otherwise out_* hold stable and out_valid stays 1.
- free_phys_valid with free_phys != 0 sets that free bit at the next edge.
  - A tag returned this cycle is not allocatable until the following cycle.
  - Tag 0 returns are ignored.
- commit_valid with commit_dest_arch != 0 writes committed RAT[arch] = commit_dest_phys.
- recover (in any state, including while out_valid=1):
  - out_valid cleared next edge; the unit enters RECOVER; no fire.
  - In RECOVER: spec RAT = committed RAT, including any commit arriving that same cycle.
  - Free vector = complement of the set of tags in the committed RAT; bit 0 stays clear.
  - Returns arriving during RECOVER are dropped; the rebuild supersedes them.
- Reset asserted mid-recovery or mid-handshake returns immediately to reset values.
- Free list empty with need_dest holds in_ready=0. Instructions with no destination still flow.

Optional Feature:
- RENAME_PERF_CNT_EN defined:
  - Adds output stall_free_cnt (32 bits), counting cycles with in_valid && need_dest && free vector empty.
  - Saturates at all-ones; cleared by reset and by recover.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rename_pkg holds:
  - Constants NUM_ARCH, NUM_PHYS, PTAG_W=6, AREG_W=5.
  - The state encoding RUN/RECOVER.
- One natural sub-module: free_list_bitvec.
  - Holds the 64-bit vector, lowest-set-bit allocate, return-set, and the rebuild-from-mask input.

Test Plan:
- Reset release, then rename rd=5, rs1=5, rs2=0 -> out_ps1=5, out_ps2=0, out_pd=32, out_old_pd=5, alloc_dest_arch=5; next rename of rs1=5 gives out_ps1=32.
- Allocate 32 destinations back-to-back with out_ready=alloc_accepted=1 -> tags 32..63; the 33rd has in_ready=0. A no-dest instruction still fires. free_phys=40 -> next cycle alloc gives 40.
- Hold alloc_accepted=0 for 3 cycles -> out_* stable, in_ready=0; release -> drains in the same cycle.
- Commit arch3 to phys 33, rename arch3 to 34, then recover -> busy_recover=1 for 1 cycle. Afterwards RAT[3]=33; 3 and 34 are allocatable; 33 is not.
- recover and a fire attempt in the same cycle -> no fire, out_valid=0 next cycle.
- Assert reset during RECOVER -> identity RAT, free bits 32..63 set, out_valid=0.
